// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control stage and the register memory bank:
// CPU state bus values, opcodes, instruction field positions and data width.
package cpu_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned INSTR_W = 17;

  localparam int unsigned OPC_MSB  = 16;
  localparam int unsigned OPC_LSB  = 14;
  localparam int unsigned A1_MSB   = 13;
  localparam int unsigned A1_LSB   = 10;
  localparam int unsigned A2_MSB   = 9;
  localparam int unsigned A2_LSB   = 6;
  localparam int unsigned A3_MSB   = 5;
  localparam int unsigned A3_LSB   = 2;
  localparam int unsigned IMM7_MSB = 6;
  localparam int unsigned IMM6_MSB = 5;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_CALC   = 3'd4,
    S_WAIT   = 3'd5,
    S_STORE  = 3'd6,
    S_SHOW   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'd0,
    OP_ADD     = 3'd1,
    OP_ADDI    = 3'd2,
    OP_SUB     = 3'd3,
    OP_SUBI    = 3'd4,
    OP_MUL     = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_DISPLAY = 3'd7
  } opcode_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: one 16-bit two's-complement result per opcode, wrapping
// silently on overflow.
module cpu_alu
  import cpu_pkg::*;
(
  input  opcode_e           opcode,
  input  logic [DATA_W-1:0] v1,
  input  logic [DATA_W-1:0] v2,
  input  logic [6:0]        imm7,
  input  logic [5:0]        imm6,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] imm7_x;
  logic [DATA_W-1:0] imm6_x;

  always_comb begin
    imm7_x = {{(DATA_W-7){imm7[6]}}, imm7};
    imm6_x = {{(DATA_W-6){imm6[5]}}, imm6};
    result = '0;
    case (opcode)
      OP_LOAD:    result = imm7_x;
      OP_ADD:     result = v1 + v2;
      OP_ADDI:    result = v1 + imm6_x;
      OP_SUB:     result = v1 - v2;
      OP_SUBI:    result = v1 - imm6_x;
      // low half of a product is the same for signed and unsigned operands
      OP_MUL:     result = v1 * imm6_x;
      OP_CLEAR:   result = '0;
      OP_DISPLAY: result = v1;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// CPU control/execute stage: synchronises power/send, latches an instruction,
// sequences the state bus through the memory handshakes and registers the ALU result.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int unsigned HS_TIMEOUT  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                power,
  input  logic                send,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [DATA_W-1:0]   v1RAM,
  input  logic [DATA_W-1:0]   v2RAM,
  input  logic                read,
  input  logic                stored,
  output logic [2:0]          stateCPU,
  output logic [2:0]          opcode,
  output logic [3:0]          addr1,
  output logic [3:0]          addr2,
  output logic [3:0]          addr3,
  output logic [DATA_W-1:0]   valorGuardarRAM,
  output logic [DATA_W-1:0]   show_value,
  output logic                show_valid,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(HS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HS_TIMEOUT - 1);

  state_e                 state_q, state_d;
  opcode_e                opcode_q, opcode_d;
  logic [3:0]             addr1_q, addr1_d;
  logic [3:0]             addr2_q, addr2_d;
  logic [3:0]             addr3_q, addr3_d;
  logic [IMM7_MSB:0]      imm7_q, imm7_d;
  logic [DATA_W-1:0]      result_q, result_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] pwr_sync_q, pwr_sync_d;
  logic [SYNC_STAGES-1:0] snd_sync_q, snd_sync_d;
  logic                   snd_prev_q, snd_prev_d;

  logic                   power_s;
  logic                   send_s;
  logic                   send_edge;
  logic [DATA_W-1:0]      alu_result;

  assign power_s   = pwr_sync_q[SYNC_STAGES-1];
  assign send_s    = snd_sync_q[SYNC_STAGES-1];
  assign send_edge = send_s & ~snd_prev_q;

  cpu_alu u_alu (
    .opcode (opcode_q),
    .v1     (v1RAM),
    .v2     (v2RAM),
    .imm7   (imm7_q),
    .imm6   (imm7_q[IMM6_MSB:0]),
    .result (alu_result)
  );

  always_comb begin
    pwr_sync_d    = pwr_sync_q << 1;
    pwr_sync_d[0] = power;
    snd_sync_d    = snd_sync_q << 1;
    snd_sync_d[0] = send;
    snd_prev_d    = send_s;

    state_d  = state_q;
    opcode_d = opcode_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    addr3_d  = addr3_q;
    imm7_d   = imm7_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = '0;

    // power loss overrides every other transition
    if (!power_s) begin
      state_d = S_OFF;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_OFF:    state_d = S_FETCH;
        S_FETCH: begin
          err_d = 1'b0;
          if (send_edge) begin
            opcode_d = opcode_e'(instr[OPC_MSB:OPC_LSB]);
            addr1_d  = instr[A1_MSB:A1_LSB];
            addr2_d  = instr[A2_MSB:A2_LSB];
            addr3_d  = instr[A3_MSB:A3_LSB];
            imm7_d   = instr[IMM7_MSB:0];
            state_d  = S_DECODE;
          end
        end
        S_DECODE: state_d = S_READ;
        S_READ: begin
          if (read) begin
            state_d = S_CALC;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_SHOW;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CALC: begin
          result_d = alu_result;
          state_d  = S_WAIT;
        end
        S_WAIT:   state_d = S_STORE;
        S_STORE: begin
          if (stored) begin
            state_d = S_SHOW;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_SHOW;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (send_edge) state_d = S_FETCH;
        end
        default:  state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      opcode_q   <= OP_LOAD;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr3_q    <= '0;
      imm7_q     <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      pwr_sync_q <= '0;
      snd_sync_q <= '0;
      snd_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr3_q    <= addr3_d;
      imm7_q     <= imm7_d;
      result_q   <= result_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      pwr_sync_q <= pwr_sync_d;
      snd_sync_q <= snd_sync_d;
      snd_prev_q <= snd_prev_d;
    end
  end

  assign stateCPU        = state_q;
  assign opcode          = opcode_q;
  assign addr1           = addr1_q;
  assign addr2           = addr2_q;
  assign addr3           = addr3_q;
  assign show_value      = result_q;
  assign show_valid      = (state_q == S_SHOW) && !err_q;
  assign err             = err_q;
  assign valorGuardarRAM = (state_q inside {S_WAIT, S_STORE, S_SHOW}) ? result_q : '0;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: bench-side memory responder, cycle model compared every
// negedge, and directed instruction/timeout/power/reset scenarios.
`timescale 1ns/1ps
module tb_cpu_control;

  localparam int HS = 8;
  localparam int SY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        power = 1'b1;
  logic        send = 1'b0;
  logic [16:0] instr = '0;
  logic [15:0] v1RAM = '0;
  logic [15:0] v2RAM = '0;
  logic        read = 1'b0;
  logic        stored = 1'b0;
  logic [2:0]  stateCPU, opcode;
  logic [3:0]  addr1, addr2, addr3;
  logic [15:0] valorGuardarRAM, show_value;
  logic        show_valid, err;

  always #5 clk = ~clk;

  cpu_control #(.HS_TIMEOUT(HS), .SYNC_STAGES(SY)) dut (
    .clk(clk), .rst_n(rst_n), .power(power), .send(send), .instr(instr),
    .v1RAM(v1RAM), .v2RAM(v2RAM), .read(read), .stored(stored),
    .stateCPU(stateCPU), .opcode(opcode), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .valorGuardarRAM(valorGuardarRAM), .show_value(show_value),
    .show_valid(show_valid), .err(err)
  );

  int vectors = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: flags rise one cycle after it first sees READ / STORE.
  bit no_read = 0, no_store = 0;
  always @(posedge clk) begin
    read   <= (stateCPU == 3'd3) && !no_read;
    stored <= (stateCPU == 3'd6) && !no_store;
  end

  // Reference arithmetic in plain signed integers, truncated to 16 bits.
  function automatic logic [15:0] alu_ref(input int op, input int a, input int b, input int imm7);
    int i7, i6, r;
    i7 = (imm7 >= 64) ? imm7 - 128 : imm7;
    i6 = imm7 & 63;
    if (i6 >= 32) i6 = i6 - 64;
    case (op)
      0: r = i7;
      1: r = a + b;
      2: r = a + i6;
      3: r = a - b;
      4: r = a - i6;
      5: r = a * i6;
      6: r = 0;
      default: r = a;
    endcase
    return 16'(r);
  endfunction

  // Model: state numbers follow the documented bus encoding.
  int m_state = 0, m_err = 0, m_dwell = 0;
  int m_opc = 0, m_a1 = 0, m_a2 = 0, m_a3 = 0, m_imm7 = 0;
  logic [15:0] m_res = '0;
  bit p_pipe[SY];
  bit s_pipe[SY];
  bit s_last = 0;

  always @(posedge clk or negedge rst_n) begin
    bit pw, sedge, done;
    if (!rst_n) begin
      m_state = 0; m_err = 0; m_dwell = 0;
      m_opc = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0; m_imm7 = 0; m_res = '0;
      for (int i = 0; i < SY; i++) begin p_pipe[i] = 0; s_pipe[i] = 0; end
      s_last = 0;
    end else begin
      pw    = p_pipe[SY-1];
      sedge = s_pipe[SY-1] && !s_last;
      s_last = s_pipe[SY-1];
      for (int i = SY-1; i > 0; i--) begin p_pipe[i] = p_pipe[i-1]; s_pipe[i] = s_pipe[i-1]; end
      p_pipe[0] = power;
      s_pipe[0] = send;
      if (!pw) begin
        m_state = 0; m_err = 0; m_dwell = 0;
      end else begin
        case (m_state)
          0: m_state = 1;
          1: begin
            m_err = 0;
            if (sedge) begin
              m_opc = int'(instr[16:14]); m_a1 = int'(instr[13:10]);
              m_a2 = int'(instr[9:6]);    m_a3 = int'(instr[5:2]);
              m_imm7 = int'(instr[6:0]);  m_state = 2;
            end
          end
          2: m_state = 3;
          3, 6: begin
            done = (m_state == 3) ? read : stored;
            m_dwell++;
            if (done) begin
              m_state = (m_state == 3) ? 4 : 7; m_dwell = 0;
            end else if (m_dwell >= HS) begin
              m_state = 7; m_err = 1; m_dwell = 0;
            end
          end
          4: begin m_res = alu_ref(m_opc, int'(v1RAM), int'(v2RAM), m_imm7); m_state = 5; end
          5: m_state = 6;
          default: if (sedge) m_state = 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", stateCPU, m_state);
      chk("err", err, m_err);
      chk("show_valid", show_valid, (m_state == 7 && m_err == 0) ? 1 : 0);
      chk("show_value", show_value, m_res);
      chk("valorGuardarRAM", valorGuardarRAM, (m_state >= 5) ? m_res : 16'h0);
      if (m_state >= 2) begin
        chk("opcode", opcode, m_opc);
        chk("addr1", addr1, m_a1);
        chk("addr2", addr2, m_a2);
        chk("addr3", addr3, m_a3);
      end
    end
  end

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (stateCPU !== 3'(s) && n < budget) begin @(negedge clk); n++; end
    chk(nm, stateCPU, s);
  endtask

  task automatic pulse_send();
    send = 1;
    repeat (4) @(negedge clk);
    send = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_instr(input string nm, input logic [16:0] iw, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp,
                           input logic [3:0] ea1, input logic [3:0] ea3);
    int n = 0;
    int lastst = 1;
    bit store_seen = 0;
    if (stateCPU == 3'd7) begin
      pulse_send();
      wait_state(1, 20, {nm, "_fetch"});
    end
    instr = iw; v1RAM = a; v2RAM = b;
    send = 1;
    while (stateCPU != 3'd7 && n < 40) begin
      @(negedge clk); n++;
      if (n == 4) send = 0;
      if (int'(stateCPU) != lastst) begin
        chk({nm, "_seq"}, stateCPU, lastst + 1);
        lastst = int'(stateCPU);
      end
      if (stateCPU == 3'd6 && !store_seen) begin
        store_seen = 1;
        chk({nm, "_store_val"}, valorGuardarRAM, exp);
        chk({nm, "_store_a1"}, addr1, ea1);
        chk({nm, "_store_a3"}, addr3, ea3);
      end
    end
    chk({nm, "_show"}, stateCPU, 7);
    chk({nm, "_show_value"}, show_value, exp);
    chk({nm, "_show_valid"}, show_valid, 1);
    send = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, cnt;
    #1 rst_n = 0;
    #1;
    chk("rst_state", stateCPU, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", show_valid, 0);
    chk("rst_value", show_value, 0);
    chk("rst_store", valorGuardarRAM, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_addr1", addr1, 0);
    chk_en = 1;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    wait_state(1, 20, "boot_fetch");

    run_instr("load",  {3'd0, 4'd3, 4'b0001, 4'b1110, 2'b11}, 16'h0000, 16'h0000, 16'hFFFB, 4'd3, 4'hE);
    run_instr("add",   {3'd1, 4'd1, 4'd2, 4'd4, 2'b00}, 16'd7, 16'd9, 16'h0010, 4'd1, 4'd4);
    run_instr("sub",   {3'd3, 4'd5, 4'd6, 4'd7, 2'b00}, 16'd0, 16'd1, 16'hFFFF, 4'd5, 4'd7);
    run_instr("mul",   {3'd5, 4'd2, 4'd0, 4'b0001, 2'b00}, 16'h4000, 16'd0, 16'h0000, 4'd2, 4'd1);
    run_instr("subi",  {3'd4, 4'd8, 4'd0, 4'b1111, 2'b11}, 16'd5, 16'd0, 16'h0006, 4'd8, 4'hF);
    run_instr("addi",  {3'd2, 4'd9, 4'd0, 4'b1000, 2'b01}, 16'h0010, 16'd0, 16'hFFF1, 4'd9, 4'h8);
    run_instr("disp",  {3'd7, 4'd4, 4'd0, 4'd0, 2'b00}, 16'h1234, 16'h5555, 16'h1234, 4'd4, 4'd0);
    run_instr("clear", {3'd6, 4'd6, 4'd0, 4'd0, 2'b00}, 16'h1234, 16'h5555, 16'h0000, 4'd6, 4'd0);

    // store handshake never completes
    pulse_send();
    wait_state(1, 20, "to_fetch_to");
    no_store = 1;
    instr = {3'd1, 4'd1, 4'd2, 4'd3, 2'b00};
    v1RAM = 16'd1; v2RAM = 16'd2;
    send = 1; n = 0; cnt = 0;
    while (stateCPU != 3'd7 && n < 60) begin
      @(negedge clk); n++;
      if (n == 4) send = 0;
      if (stateCPU == 3'd6) cnt++;
    end
    chk("to_store_cycles", cnt, 8);
    chk("to_state", stateCPU, 7);
    chk("to_err", err, 1);
    chk("to_valid", show_valid, 0);
    no_store = 0;
    pulse_send();
    chk("to_refetch", stateCPU, 1);
    chk("to_err_clr", err, 0);

    // power drop while waiting in READ
    no_read = 1;
    instr = {3'd1, 4'd2, 4'd3, 4'd4, 2'b00};
    send = 1;
    wait_state(3, 20, "pwr_read");
    send = 0;
    power = 0; n = 0;
    while (stateCPU != 3'd0 && n < 10) begin @(negedge clk); n++; end
    chk("pwr_off_cycles", n, SY + 1);
    chk("pwr_off_err", err, 0);
    chk("pwr_off_valid", show_valid, 0);
    no_read = 0;
    repeat (2) @(negedge clk);
    power = 1;
    wait_state(1, 10, "pwr_fetch");
    repeat (5) @(negedge clk);
    chk("pwr_fetch_hold", stateCPU, 1);

    // asynchronous reset between clock edges while in CALC
    instr = {3'd0, 4'd5, 4'd0, 4'd0, 2'b01};
    send = 1;
    wait_state(4, 20, "rst_calc");
    #2 rst_n = 0;
    #1;
    chk("arst_state", stateCPU, 0);
    chk("arst_opcode", opcode, 0);
    chk("arst_addr1", addr1, 0);
    chk("arst_value", show_value, 0);
    chk("arst_store", valorGuardarRAM, 0);
    @(negedge clk);
    send = 0;
    rst_n = 1;
    wait_state(1, 20, "arst_fetch");
    repeat (3) @(negedge clk);

    // send held high across a whole instruction
    instr = {3'd1, 4'd1, 4'd1, 4'd1, 2'b00};
    v1RAM = 16'd3; v2RAM = 16'd4;
    send = 1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stateCPU == 3'd4) cnt++;
    end
    chk("held_calc_count", cnt, 1);
    chk("held_state", stateCPU, 7);
    chk("held_value", show_value, 16'h0007);
    send = 0;
    repeat (4) @(negedge clk);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
